// File: rtl/moggy_button_debounce.sv
// Multi-channel push-button synchroniser, debouncer, edge pulser and IRQ latch.
// Define MOGGY_BUTTON_LONG_PRESS_EN to build in long-press detection on btn_long.
module moggy_button_debounce #(
    parameter int NUM_CH            = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 125000,
    parameter int LONG_PRESS_CYCLES = 125000000
) (
    input  logic              clk_125,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic [NUM_CH-1:0] irq_mask,
    input  logic [NUM_CH-1:0] irq_clear,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_press,
    output logic [NUM_CH-1:0] btn_release,
    output logic [NUM_CH-1:0] btn_long,
    output logic [NUM_CH-1:0] irq_pending,
    output logic              irq
);

`ifdef MOGGY_BUTTON_LONG_PRESS_EN
    localparam int CNT_MAX = (LONG_PRESS_CYCLES > DEBOUNCE_CYCLES) ?
                             LONG_PRESS_CYCLES : DEBOUNCE_CYCLES;
`else
    localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef MOGGY_BUTTON_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_SAT  = CNT_W'(LONG_PRESS_CYCLES);
`endif

    typedef enum logic [1:0] {
        IDLE_LO,
        CHK_HI,
        HELD_HI,
        CHK_LO
    } state_t;

    logic r_irq;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_nxt;
        logic                   r_level;
        logic                   w_level_nxt;
        logic                   r_press;
        logic                   w_press_nxt;
        logic                   r_release;
        logic                   w_release_nxt;
        logic                   r_pend;
`ifdef MOGGY_BUTTON_LONG_PRESS_EN
        logic                   r_long;
        logic                   w_long_nxt;
        logic                   r_done;
        logic                   w_done_nxt;
`endif

        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk_125 or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[g]};
            end
        end

        always_ff @(posedge clk_125 or posedge rst) begin
            if (rst) begin
                r_state   <= IDLE_LO;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
`ifdef MOGGY_BUTTON_LONG_PRESS_EN
                r_long    <= 1'b0;
                r_done    <= 1'b0;
`endif
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_level   <= w_level_nxt;
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
`ifdef MOGGY_BUTTON_LONG_PRESS_EN
                r_long    <= w_long_nxt;
                r_done    <= w_done_nxt;
`endif
            end
        end

        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_level_nxt   = r_level;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
`ifdef MOGGY_BUTTON_LONG_PRESS_EN
            w_long_nxt    = 1'b0;
            w_done_nxt    = r_done;
`endif
            unique case (r_state)
                IDLE_LO: begin
                    if (w_s) begin
                        w_state_nxt = CHK_HI;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                CHK_HI: begin
                    if (!w_s) begin
                        w_state_nxt = IDLE_LO;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        w_state_nxt = HELD_HI;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                HELD_HI: begin
                    if (!w_s) begin
                        w_state_nxt = CHK_LO;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
`ifdef MOGGY_BUTTON_LONG_PRESS_EN
                        if (r_cnt != LP_SAT) begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                        // One long pulse per press; a CHK_LO glitch restarts
                        // the count but does not re-arm.
                        if (r_cnt == LP_LAST && !r_done) begin
                            w_long_nxt = 1'b1;
                            w_done_nxt = 1'b1;
                        end
`endif
                    end
                end
                CHK_LO: begin
                    if (w_s) begin
                        w_state_nxt = HELD_HI;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        w_state_nxt   = IDLE_LO;
                        w_cnt_nxt     = '0;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
`ifdef MOGGY_BUTTON_LONG_PRESS_EN
                        w_done_nxt    = 1'b0;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE_LO;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Set beats clear when both land in the same cycle.
        always_ff @(posedge clk_125 or posedge rst) begin
            if (rst) begin
                r_pend <= 1'b0;
            end else begin
`ifdef MOGGY_BUTTON_LONG_PRESS_EN
                r_pend <= r_press | r_long | (r_pend & ~irq_clear[g]);
`else
                r_pend <= r_press | (r_pend & ~irq_clear[g]);
`endif
            end
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
        assign irq_pending[g] = r_pend;
`ifdef MOGGY_BUTTON_LONG_PRESS_EN
        assign btn_long[g]    = r_long;
`else
        assign btn_long[g]    = 1'b0;
`endif
    end

    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(irq_pending & irq_mask);
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_moggy_button_debounce.sv
// Directed bench for moggy_button_debounce (4 ch, 2 sync, 8 debounce, 32 long).
// Long-press expectations follow MOGGY_BUTTON_LONG_PRESS_EN as seen by the build.
module tb_moggy_button_debounce;

`ifdef MOGGY_BUTTON_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       clk_125 = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_in = 4'h0;
    logic [3:0] irq_mask = 4'hF;
    logic [3:0] irq_clear = 4'h0;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_long;
    logic [3:0] irq_pending;
    logic       irq;

    logic [3:0] acc;
    int         n_tests = 0;
    int         n_fail = 0;

    moggy_button_debounce #(
        .NUM_CH           (4),
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYCLES  (8),
        .LONG_PRESS_CYCLES(32)
    ) u_dut (
        .clk_125    (clk_125),
        .rst        (rst),
        .btn_in     (btn_in),
        .irq_mask   (irq_mask),
        .irq_clear  (irq_clear),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .irq_pending(irq_pending),
        .irq        (irq)
    );

    always #5 clk_125 = ~clk_125;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_125);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with all buttons held
        rst    = 1'b1;
        btn_in = 4'hF;
        tick(3);
        check("rst_level", btn_level, 4'h0);
        check("rst_press", btn_press, 4'h0);
        check("rst_release", btn_release, 4'h0);
        check("rst_long", btn_long, 4'h0);
        check("rst_pend", irq_pending, 4'h0);
        check("rst_irq", irq, 1'b0);
        rst = 1'b0;
        tick(9);
        check("press_early", btn_press, 4'h0);
        tick(1);
        check("press_all", btn_press, 4'hF);
        check("level_all", btn_level, 4'hF);
        tick(1);
        check("press_width", btn_press, 4'h0);
        check("pend_all", irq_pending, 4'hF);
        tick(1);
        check("irq_rise", irq, 1'b1);
        irq_clear = 4'hF;
        tick(1);
        check("pend_clr", irq_pending, 4'h0);
        irq_clear = 4'h0;
        tick(1);
        check("irq_fall", irq, 1'b0);
        btn_in = 4'h0;
        tick(9);
        check("rel_early", btn_release, 4'h0);
        tick(1);
        check("rel_all", btn_release, 4'hF);
        check("level_low", btn_level, 4'h0);
        check("rel_no_pend", irq_pending, 4'h0);
        tick(1);
        check("rel_width", btn_release, 4'h0);

        // Bounce on channel 0
        acc = 4'h0;
        for (int i = 0; i < 40; i++) begin
            btn_in[0] = ((i / 3) % 2) == 0;
            tick(1);
            acc |= btn_level | btn_press;
        end
        check("bounce_quiet", acc, 4'h0);
        btn_in[0] = 1'b1;
        tick(9);
        check("bounce_early", btn_press, 4'h0);
        tick(1);
        check("bounce_press", btn_press, 4'h1);
        check("bounce_level", btn_level, 4'h1);
        tick(1);
        check("bounce_pend", irq_pending, 4'h1);

        // Release of a held channel leaves pending alone
        btn_in[0] = 1'b0;
        tick(9);
        check("rel0_early", btn_release, 4'h0);
        tick(1);
        check("rel0", btn_release, 4'h1);
        check("rel0_pend", irq_pending, 4'h1);
        tick(1);
        check("rel0_width", btn_release, 4'h0);
        irq_clear = 4'hF;
        tick(1);
        irq_clear = 4'h0;

        // Long press on channel 2
        btn_in[2] = 1'b1;
        tick(10);
        check("lp_press", btn_press, 4'h4);
        acc = 4'h0;
        for (int k = 1; k <= 50; k++) begin
            tick(1);
            if (k == 32) check("lp_fire", btn_long, LP_EN ? 4'h4 : 4'h0);
            else acc |= btn_long;
        end
        check("lp_once", acc, 4'h0);
        check("lp_level", btn_level, 4'h4);
        btn_in[2] = 1'b0;
        tick(10);
        check("lp_rel", btn_release, 4'h4);
        btn_in[2] = 1'b1;
        tick(10);
        check("lp_repress", btn_press, 4'h4);
        tick(32);
        check("lp_rearm", btn_long, LP_EN ? 4'h4 : 4'h0);
        tick(1);
        check("lp_width", btn_long, 4'h0);
        btn_in[2] = 1'b0;
        tick(10);
        check("lp_rel2", btn_release, 4'h4);
        irq_clear = 4'hF;
        tick(1);
        irq_clear = 4'h0;
        tick(1);

        // IRQ set/clear collision on channel 3
        btn_in[3] = 1'b1;
        tick(10);
        check("irq_press", btn_press, 4'h8);
        irq_clear = 4'h8;
        tick(1);
        check("set_wins", irq_pending, 4'h8);
        tick(1);
        check("clr_next", irq_pending, 4'h0);
        check("irq_hi", irq, 1'b1);
        irq_clear = 4'h0;
        tick(1);
        check("irq_lo", irq, 1'b0);
        irq_mask = 4'h7;
        acc = 4'h0;
        for (int k = 14; k <= 46; k++) begin
            tick(1);
            acc[0] |= irq;
        end
        check("irq_masked", acc, 4'h0);
        check("mask_pend", irq_pending, LP_EN ? 4'h8 : 4'h0);
        irq_mask = 4'hF;
        tick(1);
        check("unmask_irq", irq, LP_EN);
        btn_in[3] = 1'b0;
        irq_clear = 4'hF;
        tick(1);
        irq_clear = 4'h0;
        tick(9);
        check("irq_rel", btn_release, 4'h8);
        check("irq_off", irq, 1'b0);

        // Reset in CHK_HI with cnt == 5
        btn_in[1] = 1'b1;
        acc = 4'h0;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            acc |= btn_press | btn_level;
        end
        check("mid_quiet", acc, 4'h0);
        rst = 1'b1;
        #1;
        check("mid_level", btn_level, 4'h0);
        check("mid_press", btn_press, 4'h0);
        check("mid_pend", irq_pending, 4'h0);
        tick(2);
        rst = 1'b0;
        tick(9);
        check("mid_early", btn_press, 4'h0);
        tick(1);
        check("mid_repress", btn_press, 4'h2);
        check("mid_relevel", btn_level, 4'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
